// File: rtl/palette_pkg.sv
// Shared types and default parameters for the multi-bank colour palette.
// The optional fade stage is enabled with the PALETTE_FADE_EN macro.
package palette_pkg;

    localparam int NUM_BANKS_DEF = 4;
    localparam int IDX_W_DEF     = 3;
    localparam int COLOR_W_DEF   = 4;
    localparam int KEY_IDX_DEF   = 0;
    localparam int FADE_DIV_DEF  = 833333;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } rgb_t;

    typedef enum logic {
        INIT,
        RUN
    } pal_state_e;

    typedef enum logic {
        FADE_IDLE,
        FADE_ACTIVE
    } fade_state_e;

    // Bank-select width; a single bank still gets a 1-bit select port.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Fade level/prescaler FSM plus per-channel scaler forming the output stage.
// Instantiated by palette_bank_ram only when PALETTE_FADE_EN is defined.
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF
)(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 fade_start_i,
    input  logic                 fade_dir_i,
    output logic                 fade_busy_o,
    input  logic                 in_valid_i,
    input  logic [3*COLOR_W-1:0] in_rgb_i,
    input  logic                 in_transparent_i,
    output logic                 out_valid_o,
    output logic [3*COLOR_W-1:0] out_rgb_o,
    output logic                 out_transparent_o
);

    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    fade_state_e          state_q, state_d;
    logic [3:0]           level_q, level_d;
    logic                 dir_q, dir_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [4:0]           lvl_p1;
    logic [COLOR_W+3:0]   prod [3];
    logic [3*COLOR_W-1:0] scaled;
    logic                 out_valid_q;
    logic [3*COLOR_W-1:0] out_rgb_q;
    logic                 out_transp_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FADE_IDLE;
            level_q <= 4'd15;
            dir_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        case (state_q)
            FADE_ACTIVE: begin
                if (presc_q == PW'(FADE_DIV - 1)) begin
                    presc_d = '0;
                    level_d = dir_q ? (level_q - 4'd1) : (level_q + 4'd1);
                    if (level_d == (dir_q ? 4'd0 : 4'd15)) begin
                        state_d = FADE_IDLE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: ;
        endcase
        // A new start always wins: direction reloads and the prescaler restarts.
        if (fade_start_i) begin
            dir_d   = fade_dir_i;
            presc_d = '0;
            level_d = level_q;
            state_d = (fade_dir_i ? (level_q != 4'd0) : (level_q != 4'd15))
                      ? FADE_ACTIVE : FADE_IDLE;
        end
    end

    assign fade_busy_o = (state_q == FADE_ACTIVE);
    assign lvl_p1      = {1'b0, level_q} + 5'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_scale
            assign prod[gi] = (COLOR_W+4)'(in_rgb_i[gi*COLOR_W +: COLOR_W])
                            * (COLOR_W+4)'(lvl_p1);
            assign scaled[gi*COLOR_W +: COLOR_W] = COLOR_W'(prod[gi] >> 4);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q  <= 1'b0;
            out_rgb_q    <= '0;
            out_transp_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid_i;
            if (in_valid_i) begin
                out_rgb_q    <= scaled;
                out_transp_q <= in_transparent_i;
            end
        end
    end

    assign out_valid_o       = out_valid_q;
    assign out_rgb_o         = out_rgb_q;
    assign out_transparent_o = out_transp_q;

endmodule

// File: rtl/palette_bank_ram.sv
// Runtime-writable multi-bank RGB palette with colour-key flag and post-reset clear.
// Define PALETTE_FADE_EN to add the fade output stage (latency 3 instead of 2).
module palette_bank_ram
    import palette_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int KEY_IDX   = KEY_IDX_DEF,
`ifdef PALETTE_FADE_EN
    parameter int FADE_DIV  = FADE_DIV_DEF,
`endif
    localparam int BW       = bank_w(NUM_BANKS)
)(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rd_valid_i,
    input  logic [BW-1:0]        rd_bank_i,
    input  logic [IDX_W-1:0]     rd_index_i,
    output logic                 out_valid_o,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic                 out_transparent_o,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [BW-1:0]        wr_bank_i,
    input  logic [IDX_W-1:0]     wr_index_i,
    input  logic [3*COLOR_W-1:0] wr_rgb_i,
`ifdef PALETTE_FADE_EN
    input  logic                 fade_start_i,
    input  logic                 fade_dir_i,
    output logic                 fade_busy_o,
`endif
    output logic                 init_done_o
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int DEPTH   = NUM_BANKS * ENTRIES;
    localparam int AW      = BW + IDX_W;

    pal_state_e           state_q, state_d;
    logic [AW-1:0]        clr_addr_q, clr_addr_d;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [3*COLOR_W-1:0] mem_wdata;
    logic [AW-1:0]        rd_addr;
    logic                 rd_bank_ok, wr_bank_ok;

    logic [3*COLOR_W-1:0] mem_q [DEPTH];
    logic [3*COLOR_W-1:0] rd_data_q;

    logic                 s1_valid_q, s1_zero_q, s1_transp_q;
    logic                 s1_zero_d, s1_transp_d;
    logic                 valid2_q, transp2_q;
    logic [3*COLOR_W-1:0] pix2_q;
    logic [3*COLOR_W-1:0] out_rgb;

    // Banks beyond NUM_BANKS only exist when the count is not a power of two.
    generate
        if (NUM_BANKS == (1 << BW)) begin : g_bank_pow2
            assign rd_bank_ok = 1'b1;
            assign wr_bank_ok = 1'b1;
        end else begin : g_bank_range
            assign rd_bank_ok = (rd_bank_i < BW'(NUM_BANKS));
            assign wr_bank_ok = (wr_bank_i < BW'(NUM_BANKS));
        end
    endgenerate

    assign rd_addr = {rd_bank_i, rd_index_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= INIT;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // The single write port is owned by the clear sweep in INIT and by the user in RUN.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = {wr_bank_i, wr_index_i};
        mem_wdata  = wr_rgb_i;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            RUN: begin
                mem_we = wr_valid_i & wr_bank_ok;
            end
            default: state_d = INIT;
        endcase
    end

    assign init_done_o = (state_q == RUN);
    assign wr_ready_o  = (state_q == RUN);

    // Read and write in one process gives read-before-write on a shared address.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign s1_zero_d   = (state_q == INIT) || !rd_bank_ok;
    assign s1_transp_d = s1_zero_d || (rd_index_i == IDX_W'(KEY_IDX));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_transp_q <= 1'b0;
        end else begin
            s1_valid_q  <= rd_valid_i;
            s1_zero_q   <= s1_zero_d;
            s1_transp_q <= s1_transp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid2_q  <= 1'b0;
            pix2_q    <= '0;
            transp2_q <= 1'b0;
        end else begin
            valid2_q <= s1_valid_q;
            if (s1_valid_q) begin
                pix2_q    <= s1_zero_q ? '0 : rd_data_q;
                transp2_q <= s1_transp_q;
            end
        end
    end

`ifdef PALETTE_FADE_EN
    palette_fade_ctrl #(
        .COLOR_W  (COLOR_W),
        .FADE_DIV (FADE_DIV)
    ) u_fade (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .fade_start_i      (fade_start_i),
        .fade_dir_i        (fade_dir_i),
        .fade_busy_o       (fade_busy_o),
        .in_valid_i        (valid2_q),
        .in_rgb_i          (pix2_q),
        .in_transparent_i  (transp2_q),
        .out_valid_o       (out_valid_o),
        .out_rgb_o         (out_rgb),
        .out_transparent_o (out_transparent_o)
    );
`else
    assign out_valid_o       = valid2_q;
    assign out_rgb           = pix2_q;
    assign out_transparent_o = transp2_q;
`endif

    assign red_o   = out_rgb[3*COLOR_W-1 -: COLOR_W];
    assign green_o = out_rgb[2*COLOR_W-1 -: COLOR_W];
    assign blue_o  = out_rgb[COLOR_W-1   -: COLOR_W];

endmodule

// File: tb/tb_palette_bank_ram.sv
// Randomized self-checking bench for palette_bank_ram against a per-cycle palette model.
// Builds with or without PALETTE_FADE_EN; the fade scenario only runs when it is defined.
module tb_palette_bank_ram;

    localparam int NB    = 4;
    localparam int IW    = 3;
    localparam int CW    = 4;
    localparam int KEY   = 0;
    localparam int NE    = 8;
    localparam int DEPTH = NB * NE;
`ifdef PALETTE_FADE_EN
    localparam int LAT   = 3;
    localparam int FDIV  = 2;
`else
    localparam int LAT   = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_valid = 1'b0;
    logic [1:0]    rd_bank = '0;
    logic [2:0]    rd_index = '0;
    logic          out_valid;
    logic [CW-1:0] red, green, blue;
    logic          out_transparent;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [1:0]    wr_bank = '0;
    logic [2:0]    wr_index = '0;
    logic [11:0]   wr_rgb = '0;
    logic          init_done;
`ifdef PALETTE_FADE_EN
    logic          fade_start = 1'b0;
    logic          fade_dir = 1'b0;
    logic          fade_busy;
`endif

    palette_bank_ram #(
        .NUM_BANKS (NB),
        .IDX_W     (IW),
        .COLOR_W   (CW),
`ifdef PALETTE_FADE_EN
        .FADE_DIV  (FDIV),
`endif
        .KEY_IDX   (KEY)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .rd_valid_i        (rd_valid),
        .rd_bank_i         (rd_bank),
        .rd_index_i        (rd_index),
        .out_valid_o       (out_valid),
        .red_o             (red),
        .green_o           (green),
        .blue_o            (blue),
        .out_transparent_o (out_transparent),
        .wr_valid_i        (wr_valid),
        .wr_ready_o        (wr_ready),
        .wr_bank_i         (wr_bank),
        .wr_index_i        (wr_index),
        .wr_rgb_i          (wr_rgb),
`ifdef PALETTE_FADE_EN
        .fade_start_i      (fade_start),
        .fade_dir_i        (fade_dir),
        .fade_busy_o       (fade_busy),
`endif
        .init_done_o       (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [11:0] rgb;
        bit          t;
        int          b;
        int          i;
    } rec_t;

    logic [11:0] ref_mem [NB][NE];
    rec_t        pipe_q[$];
    int          init_left = DEPTH;
    logic [11:0] last_rgb = '0;
    int          ecount = 0;
    int          cur_level = 15;
    bit          fading = 1'b0;
    int          f_t0 = 0;
    int          f_l0 = 15;
    bit          f_dir = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    // Each channel becomes floor(c * (level+1) / 16).
    function automatic logic [11:0] scale(input logic [11:0] c, input int lvl);
        logic [11:0] r;
        for (int k = 0; k < 3; k++) begin
            r[k*4 +: 4] = 4'((int'(c[k*4 +: 4]) * (lvl + 1)) / 16);
        end
        return r;
    endfunction

    // Advance one clock: update the model from the inputs sampled at this edge, then check.
    task automatic cycle();
        rec_t        rec;
        rec_t        e;
        int          lvl_used;
        logic [11:0] exp_rgb;
        bit          exp_done;
        @(posedge clk);
        ecount++;
        lvl_used = cur_level;
        if (reset) begin
            init_left = DEPTH;
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < NE; i++)
                    ref_mem[b][i] = '0;
            pipe_q.delete();
            for (int k = 0; k < LAT - 1; k++) begin
                rec = '{v: 1'b0, rgb: 12'h0, t: 1'b0, b: 0, i: 0};
                pipe_q.push_back(rec);
            end
            e = '{v: 1'b0, rgb: 12'h0, t: 1'b0, b: 0, i: 0};
            last_rgb = '0;
        end else begin
            rec.v = rd_valid;
            rec.b = int'(rd_bank);
            rec.i = int'(rd_index);
            if (init_left > 0) begin
                rec.rgb = '0;
                rec.t   = 1'b1;
            end else begin
                rec.rgb = ref_mem[rec.b][rec.i];
                rec.t   = (rec.i == KEY);
                if (wr_valid) ref_mem[wr_bank][wr_index] = wr_rgb;
            end
            if (init_left > 0) init_left--;
            pipe_q.push_back(rec);
            e = pipe_q.pop_front();
        end
`ifdef PALETTE_FADE_EN
        if (reset) begin
            cur_level = 15;
            fading    = 1'b0;
        end else if (fade_start) begin
            f_t0   = ecount;
            f_l0   = cur_level;
            f_dir  = fade_dir;
            fading = fade_dir ? (cur_level != 0) : (cur_level != 15);
        end else if (fading) begin
            int steps;
            steps = (ecount - f_t0) / FDIV;
            if (f_dir) cur_level = (f_l0 - steps < 0) ? 0 : f_l0 - steps;
            else       cur_level = (f_l0 + steps > 15) ? 15 : f_l0 + steps;
            if (cur_level == (f_dir ? 0 : 15)) fading = 1'b0;
        end
`endif
        exp_done = !reset && (init_left == 0);
        #1;
        check_eq("init_done", init_done, exp_done);
        check_eq("wr_ready", wr_ready, exp_done);
        check_eq("out_valid", out_valid, e.v);
        if (reset) check_eq("reset_transparent", out_transparent, 1'b0);
`ifdef PALETTE_FADE_EN
        check_eq("fade_busy", fade_busy, fading);
`endif
        if (e.v) begin
            exp_rgb = scale(e.rgb, lvl_used);
            check_eq("rgb", {red, green, blue}, exp_rgb);
            check_eq("transparent", out_transparent, e.t);
            $display("[TB] rd bank%0d idx%0d -> rgb=%03h transparent=%0b (exp %03h/%0b)",
                     e.b, e.i, {red, green, blue}, out_transparent, exp_rgb, e.t);
            last_rgb = exp_rgb;
        end else begin
            check_eq("rgb_hold", {red, green, blue}, last_rgb);
        end
    endtask

    task automatic drive(input bit rv, input int rb, input int ri,
                         input bit wv, input int wb, input int wi, input logic [11:0] wd);
        rd_valid = rv;
        rd_bank  = 2'(rb);
        rd_index = 3'(ri);
        wr_valid = wv;
        wr_bank  = 2'(wb);
        wr_index = 3'(wi);
        wr_rgb   = wd;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 12'h0);
    endtask

    initial begin
        int n;
        int busy_cnt;
        idle(2);
        reset = 1'b0;

        // Clear sweep with reads and ignored writes in flight.
        n = 0;
        while (!init_done && n < 100) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                  1, $urandom_range(0, 3), $urandom_range(0, 7), 12'($urandom));
            n++;
        end
        check_eq("init_cycles", n, 32);
        idle(2);

        drive(1, 2, 5, 0, 0, 0, 12'h0);
        idle(2);

        drive(0, 0, 0, 1, 1, 3, 12'hA52);
        drive(1, 1, 3, 0, 0, 0, 12'h0);
        idle(2);

        drive(0, 0, 0, 1, 0, 1, 12'h123);
        drive(1, 0, 1, 1, 0, 1, 12'hFFF);
        drive(1, 0, 1, 0, 0, 0, 12'h0);
        idle(2);

        for (int b = 0; b < NB; b++) begin
            drive(0, 0, 0, 1, b, 0, 12'h9C3);
            drive(1, b, 0, 0, 0, 0, 12'h0);
            drive(1, b, 1, 0, 0, 0, 12'h0);
        end
        idle(2);

        for (int k = 0; k < 300; k++) begin
            int rb, ri, wb, wi;
            rb = $urandom_range(0, 3);
            ri = $urandom_range(0, 7);
            wb = $urandom_range(0, 3);
            wi = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) begin
                wb = rb;
                wi = ri;
            end
            drive($urandom_range(0, 3) != 0, rb, ri, $urandom_range(0, 1), wb, wi, 12'($urandom));
        end

        // Reset with reads in flight, then confirm the whole palette reads back cleared.
        drive(1, 1, 3, 0, 0, 0, 12'h0);
        drive(1, 0, 1, 0, 0, 0, 12'h0);
        reset = 1'b1;
        drive(1, 2, 2, 0, 0, 0, 12'h0);
        reset = 1'b0;
        n = 0;
        while (!init_done && n < 100) begin
            drive(1, $urandom_range(0, 3), $urandom_range(0, 7), 0, 0, 0, 12'h0);
            n++;
        end
        check_eq("reinit_cycles", n, 32);
        for (int a = 0; a < DEPTH; a++) drive(1, a / NE, a % NE, 0, 0, 0, 12'h0);
        idle(3);

`ifdef PALETTE_FADE_EN
        drive(0, 0, 0, 1, 0, 2, 12'hF84);
        idle(1);
        fade_start = 1'b1;
        fade_dir   = 1'b1;
        busy_cnt   = 0;
        drive(1, 0, 2, 0, 0, 0, 12'h0);
        fade_start = 1'b0;
        if (fade_busy) busy_cnt++;
        for (int k = 0; k < 40; k++) begin
            drive(1, 0, 2, 0, 0, 0, 12'h0);
            if (fade_busy) busy_cnt++;
        end
        check_eq("fade_busy_cycles", busy_cnt, 30);
        fade_start = 1'b1;
        fade_dir   = 1'b0;
        drive(1, 0, 2, 0, 0, 0, 12'h0);
        fade_start = 1'b0;
        for (int k = 0; k < 12; k++) drive(1, 0, 2, 0, 0, 0, 12'h0);
        idle(3);
`else
        busy_cnt = 0;
        n = busy_cnt;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at edge %0d", ecount);
        $fatal(1, "watchdog");
    end

endmodule
